acl_frame_scheduler: RTL and testbench

Frame-level controller between the ingress frame FIFO read side and the egress stream. Buffers the first HDR_WORDS words of each frame, extracts IPv4/TCP match fields, and issues one request to the ACL lookup engine. On the verdict it either replays the buffered header and forwards the rest of the frame, or drains and discards the frame. It is the single sequencer that decides what leaves the FIFO.

---
 rtl/acl_pkg.sv | 24 ++
 rtl/acl_frame_scheduler_if.sv | 10 +
 rtl/acl_hdr_buf.sv | 50 +++++
 rtl/acl_frame_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_acl_frame_scheduler.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/acl_pkg.sv
// Shared types and header field offsets for the ACL frame scheduler.
package acl_pkg;

  typedef enum logic [2:0] {StIdle, StHdr, StLookup, StReplay, StFwd, StDrop} state_e;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

  // Word indices of the match fields within the buffered header
  localparam int unsigned ETYPE_WORD     = 3;
  localparam int unsigned PROTO_WORD     = 5;
  localparam int unsigned SRC_IP_HI_WORD = 6;
  localparam int unsigned SRC_IP_LO_WORD = 7;
  localparam int unsigned DST_IP_HI_WORD = 7;
  localparam int unsigned DST_IP_LO_WORD = 8;
  localparam int unsigned DPORT_WORD     = 9;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [7:0]  proto;
    logic [15:0] dst_port;
  } acl_key_t;

endpackage

// File: rtl/acl_frame_scheduler_if.sv
// 32-bit frame stream with valid/ready handshake and end-of-frame marker.
interface acl_frame_scheduler_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/acl_hdr_buf.sv
// Header word buffer: sequential write index, replay read pointer and match-key extraction.
module acl_hdr_buf
  import acl_pkg::*;
#(
  parameter int unsigned HDR_WORDS = 10,
  localparam int unsigned IW = $clog2(HDR_WORDS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic          wr_clr,
  input  logic [31:0]   wr_data,
  output logic [IW-1:0] wr_idx,
  input  logic          rd_adv,
  input  logic          rd_clr,
  output logic [IW-1:0] rd_ptr,
  output logic [31:0]   rd_data,
  output logic [15:0]   ethertype,
  output acl_key_t      key
);

  logic [31:0] mem [HDR_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Clear wins over advance so the last word of a header leaves the index at 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_clr)     wr_idx <= '0;
      else if (wr_en) wr_idx <= wr_idx + 1'b1;
      if (rd_clr)      rd_ptr <= '0;
      else if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_comb begin
    rd_data      = mem[rd_ptr];
    ethertype    = mem[ETYPE_WORD][31:16];
    key.src_ip   = {mem[SRC_IP_HI_WORD][15:0], mem[SRC_IP_LO_WORD][31:16]};
    key.dst_ip   = {mem[DST_IP_HI_WORD][15:0], mem[DST_IP_LO_WORD][31:16]};
    key.proto    = mem[PROTO_WORD][7:0];
    key.dst_port = mem[DPORT_WORD][31:16];
  end

endmodule

// File: rtl/acl_frame_scheduler.sv
// Buffers each frame header, runs one ACL lookup, then replays+forwards or drains the frame.
// Statistics counters are built only when ACL_STATS_EN is defined.
module acl_frame_scheduler
  import acl_pkg::*;
#(
  parameter int unsigned HDR_WORDS     = 10,
  parameter int unsigned LKP_TIMEOUT   = 64,
  parameter bit          NON_IP_PERMIT = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  acl_frame_scheduler_if.slave         s,
  acl_frame_scheduler_if.master        m,
  output logic                         lkp_req,
  output logic [31:0]                  lkp_src_ip,
  output logic [31:0]                  lkp_dst_ip,
  output logic [7:0]                   lkp_proto,
  output logic [15:0]                  lkp_dst_port,
  input  logic                         lkp_ack,
  input  logic                         lkp_permit,
  output logic [31:0]                  cnt_permit,
  output logic [31:0]                  cnt_drop,
  output logic [31:0]                  cnt_timeout
);

  localparam int unsigned IW = $clog2(HDR_WORDS + 1);
  localparam int unsigned TW = $clog2(LKP_TIMEOUT + 1);
  localparam logic [IW-1:0] LastIdx = IW'(HDR_WORDS - 1);
  localparam logic [TW-1:0] TmoLast = TW'(LKP_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic            req_q, req_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            rdy_q;
  logic            wr_en, wr_clr, rd_adv, rd_clr;
  logic [IW-1:0]   wr_idx, rd_ptr;
  logic [31:0]     rd_data;
  logic [15:0]     ethertype;
  acl_key_t        key;
  logic            is_ip, verdict_valid, verdict_permit;
  logic            inc_permit, inc_drop, inc_timeout;

  acl_hdr_buf #(.HDR_WORDS(HDR_WORDS)) u_hdr_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_clr    (wr_clr),
    .wr_data   (s.tdata),
    .wr_idx    (wr_idx),
    .rd_adv    (rd_adv),
    .rd_clr    (rd_clr),
    .rd_ptr    (rd_ptr),
    .rd_data   (rd_data),
    .ethertype (ethertype),
    .key       (key)
  );

  assign is_ip = (ethertype == ETHERTYPE_IPV4);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      last_q  <= 1'b0;
      req_q   <= 1'b0;
      timer_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      req_q   <= req_d;
      timer_q <= timer_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    req_d          = req_q;
    timer_d        = timer_q;
    wr_en          = 1'b0;
    wr_clr         = 1'b0;
    rd_adv         = 1'b0;
    rd_clr         = 1'b0;
    verdict_valid  = 1'b0;
    verdict_permit = 1'b0;
    inc_permit     = 1'b0;
    inc_drop       = 1'b0;
    inc_timeout    = 1'b0;
    s.tready       = 1'b0;
    m.tdata        = '0;
    m.tvalid       = 1'b0;
    m.tlast        = 1'b0;
    unique case (state_q)
      StIdle: begin
        // rdy_q keeps the pop low through reset and its release cycle
        s.tready = rdy_q;
        if (rdy_q && s.tvalid) begin
          wr_en = 1'b1;
          if (s.tlast) begin
            wr_clr   = 1'b1;
            inc_drop = 1'b1;
          end else begin
            state_d = StHdr;
          end
        end
      end
      StHdr: begin
        s.tready = 1'b1;
        if (s.tvalid) begin
          wr_en = 1'b1;
          if (wr_idx == LastIdx) begin
            wr_clr  = 1'b1;
            last_d  = s.tlast;
            timer_d = '0;
            req_d   = is_ip;
            state_d = StLookup;
          end else if (s.tlast) begin
            wr_clr   = 1'b1;
            inc_drop = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      StLookup: begin
        if (!is_ip) begin
          verdict_valid  = 1'b1;
          verdict_permit = NON_IP_PERMIT;
        end else if (lkp_ack && req_q) begin
          verdict_valid  = 1'b1;
          verdict_permit = lkp_permit;
          req_d          = 1'b0;
        end else if (timer_q == TmoLast) begin
          verdict_valid = 1'b1;
          inc_timeout   = 1'b1;
          req_d         = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
        if (verdict_valid) begin
          if (verdict_permit) begin
            rd_clr  = 1'b1;
            state_d = StReplay;
          end else if (last_q) begin
            inc_drop = 1'b1;
            state_d  = StIdle;
          end else begin
            state_d = StDrop;
          end
        end
      end
      StReplay: begin
        m.tvalid = 1'b1;
        m.tdata  = rd_data;
        m.tlast  = last_q && (rd_ptr == LastIdx);
        if (m.tready) begin
          rd_adv = 1'b1;
          if (rd_ptr == LastIdx) begin
            rd_clr = 1'b1;
            if (last_q) begin
              inc_permit = 1'b1;
              state_d    = StIdle;
            end else begin
              state_d = StFwd;
            end
          end
        end
      end
      StFwd: begin
        m.tdata  = s.tdata;
        m.tvalid = s.tvalid;
        m.tlast  = s.tlast;
        s.tready = m.tready;
        if (s.tvalid && m.tready && s.tlast) begin
          inc_permit = 1'b1;
          state_d    = StIdle;
        end
      end
      StDrop: begin
        s.tready = 1'b1;
        if (s.tvalid && s.tlast) begin
          inc_drop = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign lkp_req      = req_q;
  assign lkp_src_ip   = req_q ? key.src_ip   : '0;
  assign lkp_dst_ip   = req_q ? key.dst_ip   : '0;
  assign lkp_proto    = req_q ? key.proto    : '0;
  assign lkp_dst_port = req_q ? key.dst_port : '0;

`ifdef ACL_STATS_EN
  logic [31:0] cnt_permit_q, cnt_drop_q, cnt_timeout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_permit_q  <= '0;
      cnt_drop_q    <= '0;
      cnt_timeout_q <= '0;
    end else begin
      if (inc_permit && (cnt_permit_q != '1))   cnt_permit_q  <= cnt_permit_q + 32'd1;
      if (inc_drop && (cnt_drop_q != '1))       cnt_drop_q    <= cnt_drop_q + 32'd1;
      if (inc_timeout && (cnt_timeout_q != '1)) cnt_timeout_q <= cnt_timeout_q + 32'd1;
    end
  end

  assign cnt_permit  = cnt_permit_q;
  assign cnt_drop    = cnt_drop_q;
  assign cnt_timeout = cnt_timeout_q;
`else
  logic unused_stats;
  assign unused_stats = ^{inc_permit, inc_drop, inc_timeout};
  assign cnt_permit   = '0;
  assign cnt_drop     = '0;
  assign cnt_timeout  = '0;
`endif

endmodule

// File: tb/tb_acl_frame_scheduler.sv
// Directed bench for acl_frame_scheduler: permit, drop, timeout, non-IP, runt, exact-header,
// backpressure and mid-frame reset.
module tb_acl_frame_scheduler;

`ifdef ACL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lkp_req, lkp_ack, lkp_permit;
  logic [31:0] lkp_src_ip, lkp_dst_ip;
  logic [7:0]  lkp_proto;
  logic [15:0] lkp_dst_port;
  logic [31:0] cnt_permit, cnt_drop, cnt_timeout;

  acl_frame_scheduler_if s_if ();
  acl_frame_scheduler_if m_if ();

  always #5 clk = ~clk;

  acl_frame_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .s            (s_if),
    .m            (m_if),
    .lkp_req      (lkp_req),
    .lkp_src_ip   (lkp_src_ip),
    .lkp_dst_ip   (lkp_dst_ip),
    .lkp_proto    (lkp_proto),
    .lkp_dst_port (lkp_dst_port),
    .lkp_ack      (lkp_ack),
    .lkp_permit   (lkp_permit),
    .cnt_permit   (cnt_permit),
    .cnt_drop     (cnt_drop),
    .cnt_timeout  (cnt_timeout)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] frm [$];
  logic [32:0] outw [$];
  int          req_cnt, src_idx, hold_err;
  logic        mvalid_seen;
  logic [31:0] k_src, k_dst;
  logic [7:0]  k_proto;
  logic [15:0] k_dport;
  int          e_perm = 0, e_drop = 0, e_tmo = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_cnt_permit"}, cnt_permit, STATS ? 32'(e_perm) : 32'd0);
    check({tag, "_cnt_drop"}, cnt_drop, STATS ? 32'(e_drop) : 32'd0);
    check({tag, "_cnt_timeout"}, cnt_timeout, STATS ? 32'(e_tmo) : 32'd0);
  endtask

  task automatic build(input int n, input logic [31:0] w3);
    logic [31:0] w;
    frm.delete();
    for (int i = 0; i < n; i++) begin
      w = 32'h1000_0000 + 32'(i);
      if (i == 3) w = w3;
      else if (i == 5) w = 32'hCCCC_9906;
      else if (i == 6) w = 32'hDDDD_DDDD;
      else if (i == 7) w = 32'hFFFF_BAAA;
      else if (i == 8) w = 32'hBBBB_CCCC;
      else if (i == 9) w = 32'h0050_1234;
      frm.push_back(w);
    end
  endtask

  task automatic drive_src();
    if (src_idx < frm.size()) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = frm[src_idx];
      s_if.tlast  = (src_idx == frm.size() - 1);
    end else begin
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tlast  = 1'b0;
    end
  endtask

  // Cycle-driven source/sink/lookup responder; observes at negedge, drives just after posedge.
  task automatic run_frame(input int ack_delay, input logic permit, input bit rnd,
                           input int exp_out, input int abort_at);
    int          cyc, tail;
    logic        prev_stall, prev_last;
    logic [31:0] prev_data;
    outw.delete();
    req_cnt = 0; src_idx = 0; hold_err = 0; mvalid_seen = 1'b0;
    cyc = 0; tail = 0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    lkp_permit = permit;
    drive_src();
    m_if.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (tail < 2 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (prev_stall && (m_if.tvalid !== 1'b1 || m_if.tdata !== prev_data ||
                         m_if.tlast !== prev_last)) hold_err++;
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_data  = m_if.tdata;
      prev_last  = m_if.tlast;
      if (m_if.tvalid) mvalid_seen = 1'b1;
      if (m_if.tvalid && m_if.tready) outw.push_back({m_if.tlast, m_if.tdata});
      if (s_if.tvalid && s_if.tready) src_idx++;
      if (lkp_req) begin
        if (req_cnt == 0) begin
          k_src = lkp_src_ip; k_dst = lkp_dst_ip; k_proto = lkp_proto; k_dport = lkp_dst_port;
        end
        lkp_ack = (ack_delay >= 0) && (req_cnt == ack_delay);
        req_cnt++;
      end
      if (abort_at >= 0 && outw.size() >= abort_at) break;
      if (src_idx == frm.size() && outw.size() >= exp_out) tail++;
      @(posedge clk);
      #1;
      lkp_ack = 1'b0;
      drive_src();
      m_if.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (abort_at < 0) check("frame_completes_in_budget", 64'(cyc < 400), 64'd1);
  endtask

  task automatic cmp_out(input string tag, input int n);
    int mism;
    mism = 0;
    check({tag, "_out_count"}, outw.size(), n);
    for (int i = 0; i < n && i < outw.size(); i++)
      if (outw[i] !== {(i == n - 1), frm[i]}) mism++;
    check({tag, "_out_words"}, mism, 0);
  endtask

  initial begin
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0;
    m_if.tready = 1'b0; lkp_ack = 1'b0; lkp_permit = 1'b0;
    #2 rst = 1'b0;
    #10;
    check("rst_s_tready", s_if.tready, 0);
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_m_tdata", m_if.tdata, 0);
    check("rst_lkp_req", lkp_req, 0);
    check_cnts("rst");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_s_tready", s_if.tready, 1);

    // Permitted IPv4/TCP frame, ack in the fourth request cycle
    build(20, 32'h0800_AAAA);
    run_frame(3, 1'b1, 1'b0, 20, -1);
    check("permit_src_ip", k_src, 32'hDDDD_FFFF);
    check("permit_dst_ip", k_dst, 32'hBAAA_BBBB);
    check("permit_proto", k_proto, 8'h06);
    check("permit_dst_port", k_dport, 16'h0050);
    check("permit_req_cycles", req_cnt, 4);
    cmp_out("permit", 20);
    e_perm++;
    check_cnts("permit");

    // Same frame denied
    run_frame(3, 1'b0, 1'b0, 0, -1);
    check("drop_no_mvalid", mvalid_seen, 0);
    check("drop_popped", src_idx, 20);
    e_drop++;
    check_cnts("drop");

    // No ack: request held for the full timeout
    run_frame(-1, 1'b1, 1'b0, 0, -1);
    check("tmo_req_cycles", req_cnt, 64);
    check("tmo_no_mvalid", mvalid_seen, 0);
    check("tmo_popped", src_idx, 20);
    e_drop++; e_tmo++;
    check_cnts("tmo");

    // Non-IPv4 ethertype: no lookup, default drop
    build(20, 32'h86DD_0000);
    run_frame(0, 1'b1, 1'b0, 0, -1);
    check("nonip_req_cycles", req_cnt, 0);
    check("nonip_no_mvalid", mvalid_seen, 0);
    check("nonip_popped", src_idx, 20);
    e_drop++;
    check_cnts("nonip");

    // Five-word runt
    build(5, 32'h0800_AAAA);
    run_frame(0, 1'b1, 1'b0, 0, -1);
    check("runt_req_cycles", req_cnt, 0);
    check("runt_no_mvalid", mvalid_seen, 0);
    check("runt_popped", src_idx, 5);
    e_drop++;
    check_cnts("runt");

    // Frame exactly one header long: tlast on replayed word 9, back in IDLE afterwards
    build(10, 32'h0800_AAAA);
    run_frame(1, 1'b1, 1'b0, 10, -1);
    cmp_out("exact", 10);
    m_if.tready = 1'b0;
    #1;
    check("exact_idle_ready", s_if.tready, 1);
    e_perm++;
    check_cnts("exact");

    // Random egress backpressure through replay and forward
    build(30, 32'h0800_AAAA);
    run_frame(0, 1'b1, 1'b1, 30, -1);
    cmp_out("bp", 30);
    check("bp_hold_stable", hold_err, 0);
    e_perm++;
    check_cnts("bp");

    // Reset while forwarding, then a clean frame
    build(20, 32'h0800_AAAA);
    run_frame(0, 1'b1, 1'b0, 20, 12);
    rst = 1'b0;
    #1;
    check("midrst_s_tready", s_if.tready, 0);
    check("midrst_m_tvalid", m_if.tvalid, 0);
    check("midrst_m_tdata", m_if.tdata, 0);
    check("midrst_m_tlast", m_if.tlast, 0);
    check("midrst_lkp_req", lkp_req, 0);
    e_perm = 0; e_drop = 0; e_tmo = 0;
    check_cnts("midrst");
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    run_frame(2, 1'b1, 1'b0, 20, -1);
    cmp_out("after_rst", 20);
    e_perm++;
    check_cnts("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
